// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier with valid/ready
// handshakes on both sides. Operands are extended to WIDTH+1 bits so one
// signed Booth datapath serves both signed and unsigned transactions.
// Optional feature macro: BOOTH_EARLY_OUT_EN. When it is defined, the block
// finishes early once the remaining multiplier bits can only cause shifts.
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           state
);

  localparam int E  = WIDTH + 1;
  localparam int IW = $clog2(E + 1);
  localparam logic [IW-1:0] E_CNT = IW'(E);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} st_t;

  st_t            st;
  logic [E-1:0]   a, qr, mr;
  logic           q_1;
  logic [IW-1:0]  iter;

  logic [E-1:0]   m_ext, q_ext;
  logic [E-1:0]   a_upd, na, nqr;
  logic           nq1;
  logic [IW-1:0]  iter_nx;
  logic           last;

  assign state = st;

  // Operand extension: sign bit replicated only in signed mode.
  assign m_ext = {signed_mode & multiplicand[WIDTH-1], multiplicand};
  assign q_ext = {signed_mode & multiplier[WIDTH-1],   multiplier};

  // One Booth step: conditional add/sub on A, then arithmetic shift of {A,Qr,Q_1}.
  always_comb begin
    a_upd = a;
    case ({qr[0], q_1})
      2'b01:   a_upd = a + mr;
      2'b10:   a_upd = a - mr;
      default: a_upd = a;
    endcase
    na      = {a_upd[E-1], a_upd[E-1:1]};
    nqr     = {a_upd[0], qr[E-1:1]};
    nq1     = qr[0];
    iter_nx = iter + 1'b1;
    last    = (iter_nx == E_CNT);
  end

`ifdef BOOTH_EARLY_OUT_EN
  localparam logic [E-1:0] ONES = '1;
  logic [2*E-1:0] eo_res;
  logic [IW-1:0]  eo_shift;
  logic           eo_hit;

  // Early-out: if the unexamined Qr bits and Q_1 all match, every remaining
  // step is a pure shift, so apply them all at once with a barrel shift.
  always_comb begin
    eo_shift = E_CNT - iter_nx;
    eo_res   = $signed({na, nqr}) >>> eo_shift;
    eo_hit   = !last && (((nqr ^ {E{nq1}}) & (ONES >> iter_nx)) == '0);
  end
`endif

  // Control FSM and datapath registers; outputs are registered with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      a         <= '0;
      qr        <= '0;
      mr        <= '0;
      q_1       <= 1'b0;
      iter      <= '0;
      product   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (in_valid) begin
            a        <= '0;
            qr       <= q_ext;
            mr       <= m_ext;
            q_1      <= 1'b0;
            iter     <= '0;
            in_ready <= 1'b0;
            st       <= RUN;
          end
        end
        RUN: begin
          a    <= na;
          qr   <= nqr;
          q_1  <= nq1;
          iter <= iter_nx;
          if (last) begin
            product   <= {na[E-3:0], nqr};
            out_valid <= 1'b1;
            st        <= DONE;
          end
`ifdef BOOTH_EARLY_OUT_EN
          else if (eo_hit) begin
            a         <= eo_res[2*E-1:E];
            qr        <= eo_res[E-1:0];
            product   <= eo_res[2*WIDTH-1:0];
            out_valid <= 1'b1;
            st        <= DONE;
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            st        <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          st        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Parametrised sequential radix-2 Booth multiplier combining datapath and control FSM in one block. Takes a WIDTH-bit multiplicand/multiplier pair over a valid/ready handshake and computes one add/sub plus arithmetic shift per clock. Supports per-transaction signed or unsigned operands. Returns a 2*WIDTH-bit product over a second valid/ready handshake. Successor to the fixed-function Booth control FSM: the datapath is internal and the handshake supports backpressure.

## Interface
- WIDTH, default 8: operand width in bits; legal values are 2 and above.
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand pair and mode are valid.
- in_ready  output  1  block can accept an operand pair; high only in IDLE.
- signed_mode  input  1  1: operands are two's complement; 0: unsigned. Sampled on accept.
- multiplicand  input  WIDTH  operand M, sampled on accept.
- multiplier  input  WIDTH  operand Q, sampled on accept.
- out_valid  output  1  product is valid; high only in DONE.
- out_ready  input  1  consumer takes the product.
- product  output  2*WIDTH  M*Q, signed or unsigned per the captured mode.
- state  output  2  debug status: 0 = IDLE, 1 = RUN, 2 = DONE.

## Operation
- Internal width is E = WIDTH+1.
  - On accept, M and Q are extended to E bits: sign-extended if signed_mode=1, zero-extended if signed_mode=0.
  - Unsigned operands are therefore handled by the same signed Booth algorithm.
- Registers:
  - A: E bits, cleared on accept.
  - Qr: E bits, loaded with the extended Q.
  - Mr: E bits, loaded with the extended M.
  - Q_1: 1 bit, cleared on accept.
  - iter counter: holds 0..E.
- FSM:
  - IDLE: in_ready=1. When in_valid=1, load the registers, set iter=0, go to RUN.
  - RUN: each edge examines {Qr[0],Q_1}:
    - 01: A = A+Mr.
    - 10: A = A-Mr.
    - 00 or 11: A is unchanged.
    - Then {A,Qr,Q_1} is shifted right arithmetically by 1 and iter increments.
    - When iter reaches E, go to DONE.
  - DONE: out_valid=1. When out_ready=1, go to IDLE.
- Arithmetic:
  - A is updated modulo 2^E. No overflow is possible because E = WIDTH+1 bits.
  - product is the low 2*WIDTH bits of {A,Qr}.
- product holds stable from entry to DONE until the handshake completes. It keeps its last value in IDLE.
- in_valid outside IDLE is ignored and has no side effects. The operand inputs are don't-care except in the accept cycle.
- There is no back-to-back acceptance: the cycle after out_valid&&out_ready is spent in IDLE.
- signed_mode changing mid-operation has no effect; the captured mode is used.

## Timing
- Reset values: in_ready=1, out_valid=0, product=0, state=0. A, Qr, Mr, Q_1 and iter are all 0.
- rst asserted in any state, including mid-RUN or during DONE with a stalled consumer:
  - Next edge goes to IDLE and all registers clear.
  - Any in-flight result is dropped with no out_valid pulse.
- Latency (macro off): handshake at edge e, then out_valid=1 after edge e+E (WIDTH+1 RUN edges).
- Throughput: one product per WIDTH+3 cycles (accept, E RUN edges, DONE, IDLE), given out_ready=1.
- Backpressure: out_valid and product are held indefinitely while out_ready=0.

## Configuration
- BOOTH_EARLY_OUT_EN defined:
  - Check: at each RUN edge, after that edge's iteration, let k = iterations completed. If k<E and bits Qr[E-1-k:0] and Q_1 are all equal, the early-out applies.
  - Action: in the same edge, shift {A,Qr} right arithmetically by the remaining E-k positions, go to DONE, and end the operation.
  - The result is identical to the full run; only latency drops.
- BOOTH_EARLY_OUT_EN undefined: always exactly E RUN edges, and no barrel shifter is synthesised.

## Test plan
- WIDTH=8, signed: -128 × -128.
  - product=0x4000.
  - out_valid rises 9 edges after accept (macro off).
- WIDTH=8, unsigned: 255 × 255 gives product=0xFE01. Signed: -3 × 5 gives product=0xFFF1.
- Backpressure: out_ready=0 for 20 cycles after out_valid.
  - product and out_valid stay stable; in_valid=1 is ignored throughout.
  - Release out_ready: one transfer, then in_ready=1 the next cycle.
- Reset mid-RUN (after 4 edges): next edge gives state=0, product=0, in_ready=1; out_valid never pulses. A new transaction 7 × 6 gives 42.
- Macro on, WIDTH=8, signed:
  - 7 × 1 gives 7 with out_valid after 2 RUN edges.
  - 7 × 0 gives 0 after 1 RUN edge.
  - -1 × -1 gives 1, matching the full-run result.
- Random regression: 10k mixed signed/unsigned pairs at WIDTH=8 and WIDTH=16 against a reference model, with random out_ready stalls.
